// File: rtl/ipsxe_floating_point_input_decode_v1_0.sv
// IEEE-754 input unpack/classify front-end for the fl2fl converter.
// Two registered stages with valid/ready handshakes; case_judge bit0 = special, bit1 = NaN.
module ipsxe_floating_point_input_decode_v1_0 #(
  parameter int FLOAT_IN_EXP  = 8,
  parameter int FLOAT_IN_FRAC = 24,
  parameter int FLUSH_DENORM  = 1
) (
  input  logic                                  i_aclk,
  input  logic                                  i_areset_n,
  input  logic                                  i_aclken,
  input  logic                                  s_tvalid,
  output logic                                  s_tready,
  input  logic [FLOAT_IN_EXP+FLOAT_IN_FRAC-1:0] s_tdata,
  output logic                                  m_tvalid,
  input  logic                                  m_tready,
  output logic                                  sign,
  output logic [FLOAT_IN_EXP-1:0]               exp_out,
  output logic [FLOAT_IN_FRAC-1:0]              frac_out,
  output logic [1:0]                            case_judge,
  output logic                                  o_invalid,
  output logic                                  o_denorm
);

  localparam int FW = FLOAT_IN_FRAC - 1;
  localparam logic [FLOAT_IN_FRAC-1:0] NAN_FRAC = {2'b01, {(FLOAT_IN_FRAC-2){1'b0}}};

  logic                     v1_reg, v2_reg;
  logic                     adv1, adv2;
  logic                     s1_sign_reg;
  logic [FLOAT_IN_EXP-1:0]  s1_exp_reg;
  logic [FW-1:0]            s1_frac_reg;
  logic                     exp_z_reg, exp_o_reg, frac_z_reg;

  logic [FLOAT_IN_EXP-1:0]  cls_exp;
  logic [FLOAT_IN_FRAC-1:0] cls_frac;
  logic [1:0]               cls_cj;
  logic                     cls_inv, cls_den;

  assign adv2     = i_aclken & (~v2_reg | m_tready);
  assign adv1     = i_aclken & (~v1_reg | adv2);
  assign s_tready = adv1 & i_areset_n;
  assign m_tvalid = v2_reg;

  // Stage 1: capture the word and pre-compute the field-compare flags.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      v1_reg      <= 1'b0;
      s1_sign_reg <= 1'b0;
      s1_exp_reg  <= '0;
      s1_frac_reg <= '0;
      exp_z_reg   <= 1'b0;
      exp_o_reg   <= 1'b0;
      frac_z_reg  <= 1'b0;
    end else if (adv1) begin
      v1_reg <= s_tvalid;
      if (s_tvalid) begin
        s1_sign_reg <= s_tdata[FLOAT_IN_EXP+FW];
        s1_exp_reg  <= s_tdata[FW +: FLOAT_IN_EXP];
        s1_frac_reg <= s_tdata[FW-1:0];
        exp_z_reg   <= (s_tdata[FW +: FLOAT_IN_EXP] == '0);
        exp_o_reg   <= (s_tdata[FW +: FLOAT_IN_EXP] == '1);
        frac_z_reg  <= (s_tdata[FW-1:0] == '0);
      end
    end
  end

  always_comb begin
    cls_exp  = s1_exp_reg;
    cls_frac = {1'b1, s1_frac_reg};
    cls_cj   = 2'b00;
    cls_inv  = 1'b0;
    cls_den  = 1'b0;
    if (exp_z_reg) begin
      cls_exp = '0;
      if (frac_z_reg) begin
        cls_frac = '0;
        cls_cj   = 2'b01;
      end else begin
        cls_den = 1'b1;
        if (FLUSH_DENORM != 0) begin
          cls_frac = '0;
          cls_cj   = 2'b01;
        end else begin
          cls_frac = {1'b0, s1_frac_reg};
        end
      end
    end else if (exp_o_reg) begin
      cls_exp = '1;
      if (frac_z_reg) begin
        cls_frac = '0;
        cls_cj   = 2'b01;
      end else begin
        // Every NaN leaves as the canonical quiet NaN; only the sNaN flag survives.
        cls_frac = NAN_FRAC;
        cls_cj   = 2'b11;
        cls_inv  = ~s1_frac_reg[FW-1];
      end
    end
  end

  // Stage 2: output registers; only overwritten when a valid word moves in.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      v2_reg     <= 1'b0;
      sign       <= 1'b0;
      exp_out    <= '0;
      frac_out   <= '0;
      case_judge <= 2'b00;
      o_invalid  <= 1'b0;
      o_denorm   <= 1'b0;
    end else if (adv2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        sign       <= s1_sign_reg;
        exp_out    <= cls_exp;
        frac_out   <= cls_frac;
        case_judge <= cls_cj;
        o_invalid  <= cls_inv;
        o_denorm   <= cls_den;
      end
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_input_decode_v1_0.sv
// Directed self-checking bench for the floating-point input decoder (flush and pass-through instances).
module tb_ipsxe_floating_point_input_decode_v1_0;

  logic        i_aclk = 1'b0;
  logic        i_areset_n = 1'b0;
  logic        i_aclken = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b1;
  logic [31:0] s_tdata = 32'h0;

  logic        s_tready_f, m_tvalid_f, sign_f, inv_f, den_f;
  logic [7:0]  exp_f;
  logic [23:0] frac_f;
  logic [1:0]  cj_f;
  logic        s_tready_n, m_tvalid_n, sign_n, inv_n, den_n;
  logic [7:0]  exp_n;
  logic [23:0] frac_n;
  logic [1:0]  cj_n;

  logic [36:0] out_f, out_n, snap;
  assign out_f = {sign_f, exp_f, frac_f, cj_f, inv_f, den_f};
  assign out_n = {sign_n, exp_n, frac_n, cj_n, inv_n, den_n};

  ipsxe_floating_point_input_decode_v1_0 #(
    .FLOAT_IN_EXP(8), .FLOAT_IN_FRAC(24), .FLUSH_DENORM(1)
  ) dut (
    .i_aclk(i_aclk), .i_areset_n(i_areset_n), .i_aclken(i_aclken),
    .s_tvalid(s_tvalid), .s_tready(s_tready_f), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid_f), .m_tready(m_tready),
    .sign(sign_f), .exp_out(exp_f), .frac_out(frac_f), .case_judge(cj_f),
    .o_invalid(inv_f), .o_denorm(den_f)
  );

  ipsxe_floating_point_input_decode_v1_0 #(
    .FLOAT_IN_EXP(8), .FLOAT_IN_FRAC(24), .FLUSH_DENORM(0)
  ) dut_nf (
    .i_aclk(i_aclk), .i_areset_n(i_areset_n), .i_aclken(i_aclken),
    .s_tvalid(s_tvalid), .s_tready(s_tready_n), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid_n), .m_tready(m_tready),
    .sign(sign_n), .exp_out(exp_n), .frac_out(frac_n), .case_judge(cj_n),
    .o_invalid(inv_n), .o_denorm(den_n)
  );

  always #5 i_aclk = ~i_aclk;

  int n_cmp = 0;
  int n_err = 0;
  int sent, rcvd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [36:0] pk(input logic s, input logic [7:0] e, input logic [23:0] f,
                                     input logic [1:0] cj, input logic inv, input logic den);
    return {s, e, f, cj, inv, den};
  endfunction

  // Accept one word, check 2-cycle latency, then compare both instances.
  task automatic send_one(input logic [31:0] w, input string tag,
                          input logic [36:0] exp_fl, input logic [36:0] exp_nf);
    @(negedge i_aclk);
    s_tvalid = 1'b1;
    s_tdata  = w;
    #1;
    chk({tag, "_rdy"}, 64'(s_tready_f), 64'd1);
    @(negedge i_aclk);
    s_tvalid = 1'b0;
    s_tdata  = 32'hDEADBEEF;
    chk({tag, "_lat1"}, 64'(m_tvalid_f), 64'd0);
    @(negedge i_aclk);
    chk({tag, "_vld"}, 64'(m_tvalid_f), 64'd1);
    chk({tag, "_vld_nf"}, 64'(m_tvalid_n), 64'd1);
    chk(tag, 64'(out_f), 64'(exp_fl));
    chk({tag, "_nf"}, 64'(out_n), 64'(exp_nf));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_vld", 64'(m_tvalid_f), 64'd0);
    chk("rst_rdy", 64'(s_tready_f), 64'd0);
    chk("rst_out", 64'(out_f), 64'd0);
    @(negedge i_aclk);
    i_areset_n = 1'b1;

    // Directed classification vectors
    send_one(32'h3F800000, "one",   pk(0, 8'h7F, 24'h800000, 2'b00, 0, 0), pk(0, 8'h7F, 24'h800000, 2'b00, 0, 0));
    send_one(32'h7F7FFFFF, "maxn",  pk(0, 8'hFE, 24'hFFFFFF, 2'b00, 0, 0), pk(0, 8'hFE, 24'hFFFFFF, 2'b00, 0, 0));
    send_one(32'h7FC00000, "qnan",  pk(0, 8'hFF, 24'h400000, 2'b11, 0, 0), pk(0, 8'hFF, 24'h400000, 2'b11, 0, 0));
    send_one(32'h7F800001, "snan",  pk(0, 8'hFF, 24'h400000, 2'b11, 1, 0), pk(0, 8'hFF, 24'h400000, 2'b11, 1, 0));
    send_one(32'hFFC00001, "nnan",  pk(1, 8'hFF, 24'h400000, 2'b11, 0, 0), pk(1, 8'hFF, 24'h400000, 2'b11, 0, 0));
    send_one(32'hFF800000, "ninf",  pk(1, 8'hFF, 24'h000000, 2'b01, 0, 0), pk(1, 8'hFF, 24'h000000, 2'b01, 0, 0));
    send_one(32'h80000000, "nzero", pk(1, 8'h00, 24'h000000, 2'b01, 0, 0), pk(1, 8'h00, 24'h000000, 2'b01, 0, 0));
    send_one(32'h00000001, "dmin",  pk(0, 8'h00, 24'h000000, 2'b01, 0, 1), pk(0, 8'h00, 24'h000001, 2'b00, 0, 1));
    send_one(32'h807FFFFF, "dmax",  pk(1, 8'h00, 24'h000000, 2'b01, 0, 1), pk(1, 8'h00, 24'h7FFFFF, 2'b00, 0, 1));
    send_one(32'h00800000, "nmin",  pk(0, 8'h01, 24'h800000, 2'b00, 0, 0), pk(0, 8'h01, 24'h800000, 2'b00, 0, 0));

    // Clock enable low freezes the block
    @(negedge i_aclk);
    s_tvalid = 1'b1;
    s_tdata  = 32'h40000005;
    @(negedge i_aclk);
    s_tvalid = 1'b0;
    @(negedge i_aclk);
    i_aclken = 1'b0;
    #1;
    chk("cen_rdy", 64'(s_tready_f), 64'd0);
    @(negedge i_aclk);
    chk("cen_vld", 64'(m_tvalid_f), 64'd1);
    chk("cen_out", 64'(out_f), 64'(pk(0, 8'h80, 24'h800005, 2'b00, 0, 0)));
    i_aclken = 1'b1;
    @(negedge i_aclk);
    chk("cen_drain", 64'(m_tvalid_f), 64'd0);

    // Stream of 8 words with m_tready low for cycles 3-6
    sent = 0;
    rcvd = 0;
    snap = '0;
    for (int c = 0; c < 60 && rcvd < 8; c++) begin
      @(negedge i_aclk);
      m_tready = !(c >= 3 && c <= 6);
      s_tvalid = (sent < 8);
      s_tdata  = 32'h40000000 | 32'(sent);
      #1;
      if (c >= 3 && c <= 6) begin
        chk("stall_rdy", 64'(s_tready_f), 64'd0);
        chk("stall_vld", 64'(m_tvalid_f), 64'd1);
      end
      if (c == 3) snap = out_f;
      else if (c >= 4 && c <= 6) chk("stall_hold", 64'(out_f), 64'(snap));
      if (m_tvalid_f && m_tready) begin
        chk("stream_data", 64'(out_f), 64'(pk(0, 8'h80, 24'h800000 | 24'(rcvd), 2'b00, 0, 0)));
        rcvd++;
      end
      if (s_tvalid && s_tready_f) sent++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    chk("stream_rcvd", 64'(rcvd), 64'd8);
    chk("stream_sent", 64'(sent), 64'd8);
    @(negedge i_aclk);
    @(negedge i_aclk);
    chk("stream_empty", 64'(m_tvalid_f), 64'd0);

    // Asynchronous reset with both stages full
    @(negedge i_aclk);
    s_tvalid = 1'b1;
    s_tdata  = 32'h40000001;
    @(negedge i_aclk);
    s_tdata  = 32'h40000002;
    @(negedge i_aclk);
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    chk("prerst_vld", 64'(m_tvalid_f), 64'd1);
    #2;
    i_areset_n = 1'b0;
    #1;
    chk("arst_vld", 64'(m_tvalid_f), 64'd0);
    chk("arst_out", 64'(out_f), 64'd0);
    chk("arst_out_nf", 64'(out_n), 64'd0);
    chk("arst_rdy", 64'(s_tready_f), 64'd0);
    @(negedge i_aclk);
    #2;
    i_areset_n = 1'b1;
    m_tready = 1'b1;
    @(negedge i_aclk);
    chk("postrst_vld", 64'(m_tvalid_f), 64'd0);
    send_one(32'h3F800000, "postrst", pk(0, 8'h7F, 24'h800000, 2'b00, 0, 0), pk(0, 8'h7F, 24'h800000, 2'b00, 0, 0));
    @(negedge i_aclk);
    chk("postrst_drain", 64'(m_tvalid_f), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
